vc_pop_arbiter: RTL and testbench
=================================

VC_POP_ARBITER -- requirements
Module: vc_pop_arbiter

Interface
REQ-001 Parameter WEIGHT0, default 3, maximum consecutive pops from class-0 FIFO per turn (1..15).
REQ-002 Parameter WEIGHT1, default 1, maximum consecutive pops from class-1 FIFO per turn (1..15).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 fifo0_empty  input  1  class-0 FIFO empty flag.
REQ-006 fifo1_empty  input  1  class-1 FIFO empty flag.
REQ-007 fifo0_data  input  8  class-0 FIFO read data, valid one cycle after pop_0.
REQ-008 fifo1_data  input  8  class-1 FIFO read data, valid one cycle after pop_1.
REQ-009 dest_almost_full  input  1  downstream backpressure; 1 = no new pops.
REQ-010 pop_0  output  1  registered pop strobe to class-0 FIFO.
REQ-011 pop_1  output  1  registered pop strobe to class-1 FIFO.
REQ-012 data_out  output  8  registered forwarded byte.
REQ-013 valid_out  output  1  data_out qualifier.
REQ-014 grant  output  1  class of the byte on data_out (0/1).

Function
REQ-015 FSM states IDLE, SERVE0, SERVE1; pop_0 only in SERVE0, pop_1 only in SERVE1, never both in one cycle.
REQ-016 Pop rule: pop_x=1 in a cycle iff state SERVEx, fifox_empty=0, dest_almost_full=0.
REQ-017 Latency: pop in cycle N -> fifo data sampled cycle N+1 -> data_out/valid_out/grant valid cycle N+2; valid_out high exactly one cycle per pop.
REQ-018 Burst counter (4 bits) loads WEIGHTx on entry to SERVEx, decrements per pop; at zero, switch to other class if its FIFO non-empty, else reload and stay.
REQ-019 Current FIFO empty mid-burst: switch to other class if non-empty, else IDLE.
REQ-020 IDLE with both FIFOs non-empty: enter the class not last served (last_served register); with one non-empty: enter that class; both empty: stay IDLE.
REQ-021 dest_almost_full=1: no pops, state and counter frozen; in-flight byte from previous pop still delivered on data_out.
REQ-022 Simultaneous counter zero and other FIFO becoming non-empty in the same cycle: switch (sampled flags govern).
REQ-023 data_out holds last value when valid_out=0.

Reset
REQ-024 reset=0 at clk edge: state IDLE, pop_0=pop_1=0, data_out=8'h00, valid_out=0, grant=0, counter=0, last_served=1 (class 0 wins first tie).
REQ-025 reset mid-burst discards any in-flight byte; valid_out=0 the cycle after reset asserted.

Configuration
REQ-026 Macro VC_ARB_STATS_EN defined: adds outputs cnt0, cnt1 (16 bits each), incremented per valid_out of class 0/1, saturating at 16'hFFFF, cleared by reset.
REQ-027 VC_ARB_STATS_EN undefined: cnt0/cnt1 ports and logic absent; all other behaviour identical.

Structure
REQ-028 Shared package vc_arb_pkg holds FSM state enum (IDLE=2'd0, SERVE0=2'd1, SERVE1=2'd2), burst counter width constant (4), data width constant (8).
REQ-029 Single sub-module arb_burst_cnt (load/decrement/zero flag) instantiated once; FSM and datapath in top.

Verification
REQ-030 FIFO0 holds 8 bytes, FIFO1 empty, WEIGHT0=3 -> 8 consecutive pop_0, data_out bytes in order, grant=0, no pop_1.
REQ-031 Both FIFOs hold 8 bytes, weights 3/1 -> pop pattern 0,0,0,1,0,0,0,1...; first valid_out 2 cycles after first pop_0.
REQ-032 dest_almost_full raised mid-burst after 2nd pop_0 for 4 cycles -> pops stop next cycle, one in-flight byte delivered, burst resumes with 1 pop_0 left then switch.
REQ-033 FIFO0 empties after 1 pop, FIFO1 has 2 bytes -> SERVE1, 2 pop_1, then IDLE with no pops.
REQ-034 reset asserted during SERVE1 with byte in flight -> next cycle all outputs zero, state IDLE; on release with both non-empty, class 0 served first.
REQ-035 VC_ARB_STATS_EN build, 70000 class-0 bytes -> cnt0=16'hFFFF held, cnt1=0.

Source files
------------

// File: rtl/vc_arb_pkg.sv
// Shared types and widths for the two-class weighted FIFO pop arbiter.
package vc_arb_pkg;

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SERVE0 = 2'd1,
      SERVE1 = 2'd2
   } state_e;

endpackage

// File: rtl/arb_burst_cnt.sv
// Burst budget counter: load on class entry, decrement per pop, flag the last pop of a burst.
module arb_burst_cnt
   import vc_arb_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   // High when the pop happening now drains the budget to zero.
   assign o_zero = (r_cnt <= CNT_W'(1));

endmodule

// File: rtl/vc_pop_arbiter.sv
// Weighted two-class FIFO pop arbiter with a two-cycle pop-to-output pipeline.
// Define VC_ARB_STATS_EN to add saturating per-class delivery counters cnt0/cnt1.
module vc_pop_arbiter
   import vc_arb_pkg::*;
#(
   parameter int unsigned WEIGHT0 = 3,
   parameter int unsigned WEIGHT1 = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fifo0_empty,
   input  logic              fifo1_empty,
   input  logic [DATA_W-1:0] fifo0_data,
   input  logic [DATA_W-1:0] fifo1_data,
   input  logic              dest_almost_full,
   output logic              pop_0,
   output logic              pop_1,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              grant
`ifdef VC_ARB_STATS_EN
   ,
   output logic [15:0]       cnt0,
   output logic [15:0]       cnt1
`endif
);

   localparam logic [CNT_W-1:0] WGT0 = CNT_W'(WEIGHT0);
   localparam logic [CNT_W-1:0] WGT1 = CNT_W'(WEIGHT1);

   state_e            r_state;
   state_e            w_state_d;
   logic              r_last;
   logic              w_last_d;
   logic              w_enter;
   logic              w_enter_cls;
   logic              w_load;
   logic [CNT_W-1:0]  w_load_val;
   logic              w_zero;
   logic              r_inflight;
   logic              r_inflight_cls;
   logic              r_valid;
   logic              r_grant;
   logic [DATA_W-1:0] r_data;

   // Pops are decoded from the registered state; held off while reset is asserted.
   assign pop_0 = reset & (r_state == SERVE0) & ~fifo0_empty & ~dest_almost_full;
   assign pop_1 = reset & (r_state == SERVE1) & ~fifo1_empty & ~dest_almost_full;

   always_comb begin
      w_state_d   = r_state;
      w_enter     = 1'b0;
      w_enter_cls = 1'b0;
      w_last_d    = r_last;
      if (pop_0) begin
         w_last_d = 1'b0;
      end else if (pop_1) begin
         w_last_d = 1'b1;
      end
      if (!dest_almost_full) begin
         unique case (r_state)
            IDLE: begin
               if (!fifo0_empty && !fifo1_empty) begin
                  w_enter     = 1'b1;
                  w_enter_cls = ~r_last;
               end else if (!fifo0_empty) begin
                  w_enter     = 1'b1;
                  w_enter_cls = 1'b0;
               end else if (!fifo1_empty) begin
                  w_enter     = 1'b1;
                  w_enter_cls = 1'b1;
               end
            end
            SERVE0: begin
               if (fifo0_empty) begin
                  w_state_d   = IDLE;
                  w_enter     = ~fifo1_empty;
                  w_enter_cls = 1'b1;
               end else if (w_zero) begin
                  // Burst spent: hand over if the other class waits, else re-enter this one.
                  w_enter     = 1'b1;
                  w_enter_cls = ~fifo1_empty;
               end
            end
            SERVE1: begin
               if (fifo1_empty) begin
                  w_state_d   = IDLE;
                  w_enter     = ~fifo0_empty;
                  w_enter_cls = 1'b0;
               end else if (w_zero) begin
                  w_enter     = 1'b1;
                  w_enter_cls = fifo0_empty;
               end
            end
            default: w_state_d = IDLE;
         endcase
      end
      if (w_enter) begin
         w_state_d = w_enter_cls ? SERVE1 : SERVE0;
      end
   end

   assign w_load     = w_enter;
   assign w_load_val = w_enter_cls ? WGT1 : WGT0;

   arb_burst_cnt u_burst_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_dec      (pop_0 | pop_1),
      .o_zero     (w_zero)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state        <= IDLE;
         r_last         <= 1'b1;
         r_inflight     <= 1'b0;
         r_inflight_cls <= 1'b0;
         r_valid        <= 1'b0;
         r_grant        <= 1'b0;
         r_data         <= '0;
      end else begin
         r_state        <= w_state_d;
         r_last         <= w_last_d;
         r_inflight     <= pop_0 | pop_1;
         r_inflight_cls <= pop_1;
         r_valid        <= r_inflight;
         if (r_inflight) begin
            r_data  <= r_inflight_cls ? fifo1_data : fifo0_data;
            r_grant <= r_inflight_cls;
         end
      end
   end

   assign data_out  = r_data;
   assign valid_out = r_valid;
   assign grant     = r_grant;

`ifdef VC_ARB_STATS_EN
   logic [15:0] r_cnt0;
   logic [15:0] r_cnt1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else if (r_valid) begin
         if (!r_grant && (r_cnt0 != 16'hFFFF)) begin
            r_cnt0 <= r_cnt0 + 16'd1;
         end
         if (r_grant && (r_cnt1 != 16'hFFFF)) begin
            r_cnt1 <= r_cnt1 + 16'd1;
         end
      end
   end

   assign cnt0 = r_cnt0;
   assign cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Bench for vc_pop_arbiter: FIFO emulation, per-cycle reference model, directed and random traffic.
module tb_vc_pop_arbiter;

   localparam int W0 = 3;
   localparam int W1 = 1;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       fifo0_empty = 1'b1;
   logic       fifo1_empty = 1'b1;
   logic [7:0] fifo0_data = 8'h00;
   logic [7:0] fifo1_data = 8'h00;
   logic       dest_almost_full = 1'b0;
   logic       pop_0;
   logic       pop_1;
   logic [7:0] data_out;
   logic       valid_out;
   logic       grant;
`ifdef VC_ARB_STATS_EN
   logic [15:0] cnt0;
   logic [15:0] cnt1;
`endif

   vc_pop_arbiter #(.WEIGHT0(W0), .WEIGHT1(W1)) dut (
      .clk              (clk),
      .reset            (reset),
      .fifo0_empty      (fifo0_empty),
      .fifo1_empty      (fifo1_empty),
      .fifo0_data       (fifo0_data),
      .fifo1_data       (fifo1_data),
      .dest_almost_full (dest_almost_full),
      .pop_0            (pop_0),
      .pop_1            (pop_1),
      .data_out         (data_out),
      .valid_out        (valid_out),
      .grant            (grant)
`ifdef VC_ARB_STATS_EN
      ,
      .cnt0             (cnt0),
      .cnt1             (cnt1)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;
   bit seen0 = 1'b0;
   bit seen1 = 1'b0;
   int cyc = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];

   int pop_cls[$];
   int pop_cyc[$];
   int out_byte[$];
   int out_grant[$];
   int out_cyc[$];

   // Reference model: served class (-1 = none), pops left in burst, last class served.
   int         m_srv = -1;
   int         m_left = 0;
   int         m_last = 1;
   bit         m_v1 = 1'b0;
   int         m_c1 = 0;
   logic [7:0] m_b1 = 8'h00;
   bit         m_vo = 1'b0;
   logic [7:0] m_do = 8'h00;
   int         m_go = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int wt(input int c);
      return (c != 0) ? W1 : W0;
   endfunction

   function automatic void start(input int c);
      m_srv  = c;
      m_left = wt(c);
   endfunction

   initial begin
      bit e0, e1, af, xp0, xp1;
      int cur;
      bit ecur, eoth;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            e0  = fifo0_empty;
            e1  = fifo1_empty;
            af  = dest_almost_full;
            xp0 = reset && (m_srv == 0) && !e0 && !af;
            xp1 = reset && (m_srv == 1) && !e1 && !af;
            chk("pop_0", int'(pop_0), int'(xp0));
            chk("pop_1", int'(pop_1), int'(xp1));
            chk("valid_out", int'(valid_out), int'(m_vo));
            chk("data_out", int'(data_out), int'(m_do));
            chk("grant", int'(grant), m_go);
            if (!reset) begin
               m_srv = -1; m_left = 0; m_last = 1;
               m_v1 = 1'b0; m_vo = 1'b0; m_do = 8'h00; m_go = 0;
            end else begin
               m_vo = m_v1;
               if (m_v1) begin
                  m_do = m_b1;
                  m_go = m_c1;
               end
               m_v1 = xp0 || xp1;
               m_c1 = xp1 ? 1 : 0;
               if (xp0) m_b1 = q0[0];
               else if (xp1) m_b1 = q1[0];
               if (!af) begin
                  if (m_srv < 0) begin
                     if (!e0 && !e1) start(1 - m_last);
                     else if (!e0) start(0);
                     else if (!e1) start(1);
                  end else begin
                     cur  = m_srv;
                     ecur = (cur != 0) ? e1 : e0;
                     eoth = (cur != 0) ? e0 : e1;
                     if (ecur) begin
                        if (!eoth) start(1 - cur);
                        else m_srv = -1;
                     end else begin
                        m_last = cur;
                        m_left--;
                        if (m_left == 0) begin
                           if (!eoth) start(1 - cur);
                           else m_left = wt(cur);
                        end
                     end
                  end
               end
            end
         end
         if (pop_0) begin pop_cls.push_back(0); pop_cyc.push_back(cyc); end
         if (pop_1) begin pop_cls.push_back(1); pop_cyc.push_back(cyc); end
         if (valid_out) begin
            out_byte.push_back(int'(data_out));
            out_grant.push_back(int'(grant));
            out_cyc.push_back(cyc);
         end
         seen0 = pop_0;
         seen1 = pop_1;
         cyc++;
      end
   end

   // FIFO emulation: a pop seen this cycle presents the head byte in the next cycle.
   task automatic step();
      @(posedge clk);
      #1;
      if (seen0 && (q0.size() > 0)) fifo0_data = q0.pop_front();
      if (seen1 && (q1.size() > 0)) fifo1_data = q1.pop_front();
      fifo0_empty = (q0.size() == 0);
      fifo1_empty = (q1.size() == 0);
   endtask

   task automatic push0(input logic [7:0] b);
      q0.push_back(b);
      fifo0_empty = 1'b0;
   endtask

   task automatic push1(input logic [7:0] b);
      q1.push_back(b);
      fifo1_empty = 1'b0;
   endtask

   task automatic clear_logs();
      pop_cls.delete(); pop_cyc.delete();
      out_byte.delete(); out_grant.delete(); out_cyc.delete();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   function automatic int count_cls(input int c);
      int n = 0;
      foreach (pop_cls[i]) if (pop_cls[i] == c) n++;
      return n;
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int pat[8];
      int k;
      step();
      step();
      chk_en = 1'b1;
      #1;
      chk("reset pop_0", int'(pop_0), 0);
      chk("reset pop_1", int'(pop_1), 0);
      chk("reset valid_out", int'(valid_out), 0);
      chk("reset data_out", int'(data_out), 0);
      chk("reset grant", int'(grant), 0);
      step();
      reset = 1'b1;

      // Class 0 only: eight consecutive pops, bytes in order.
      clear_logs();
      for (int i = 0; i < 8; i++) push0(8'h10 + 8'(i));
      repeat (16) step();
      chk("A pop0 count", count_cls(0), 8);
      chk("A pop1 count", count_cls(1), 0);
      chk("A out count", out_byte.size(), 8);
      for (int i = 0; i < out_byte.size() && i < 8; i++) begin
         chk("A byte", out_byte[i], 8'h10 + i);
         chk("A grant", out_grant[i], 0);
      end
      if (pop_cyc.size() == 8) chk("A back-to-back", pop_cyc[7] - pop_cyc[0], 7);

      // Both classes loaded: 3:1 weighted pattern, class 0 first after reset.
      do_reset();
      clear_logs();
      for (int i = 0; i < 8; i++) begin
         push0(8'h20 + 8'(i));
         push1(8'h40 + 8'(i));
      end
      repeat (30) step();
      pat = '{0, 0, 0, 1, 0, 0, 0, 1};
      chk("B pop total", pop_cls.size(), 16);
      for (int i = 0; i < 8 && i < pop_cls.size(); i++) chk("B pattern", pop_cls[i], pat[i]);
      if (pop_cyc.size() > 0 && out_cyc.size() > 0)
         chk("B first latency", out_cyc[0] - pop_cyc[0], 2);
      if (out_byte.size() > 3) chk("B 4th byte", out_byte[3], 8'h40);

      // Backpressure after the second pop for four cycles.
      do_reset();
      clear_logs();
      for (int i = 0; i < 8; i++) begin
         push0(8'h30 + 8'(i));
         push1(8'h50 + 8'(i));
      end
      k = 0;
      while (pop_cls.size() < 2 && k < 20) begin
         step();
         k++;
      end
      chk("C reached 2 pops", pop_cls.size(), 2);
      dest_almost_full = 1'b1;
      repeat (4) step();
      dest_almost_full = 1'b0;
      repeat (10) step();
      if (pop_cyc.size() >= 4) begin
         chk("C stall gap", pop_cyc[2] - pop_cyc[1], 5);
         chk("C 3rd class", pop_cls[2], 0);
         chk("C 4th class", pop_cls[3], 1);
         chk("C 4th follows", pop_cyc[3] - pop_cyc[2], 1);
      end else begin
         chk("C pop count", pop_cls.size(), 4);
      end
      if (out_cyc.size() >= 2) chk("C in-flight delivered", out_cyc[1] - pop_cyc[1], 2);
      repeat (20) step();

      // Class 0 empties after one pop, class 1 takes over, then idle.
      do_reset();
      clear_logs();
      push0(8'h55);
      push1(8'h66);
      push1(8'h67);
      repeat (12) step();
      chk("D pop count", pop_cls.size(), 3);
      if (pop_cls.size() == 3) begin
         chk("D pop0", pop_cls[0], 0);
         chk("D pop1a", pop_cls[1], 1);
         chk("D pop1b", pop_cls[2], 1);
         chk("D switch gap", pop_cyc[1] - pop_cyc[0], 2);
      end
      if (out_byte.size() == 3) chk("D last byte", out_byte[2], 8'h67);

      // Reset while class 1 has a byte in flight.
      do_reset();
      clear_logs();
      for (int i = 0; i < 4; i++) push1(8'h70 + 8'(i));
      k = 0;
      while (pop_cls.size() < 1 && k < 10) begin
         step();
         k++;
      end
      chk("E pop1 seen", count_cls(1), 1);
      reset = 1'b0;
      step();
      #1;
      chk("E valid_out", int'(valid_out), 0);
      chk("E data_out", int'(data_out), 0);
      chk("E grant", int'(grant), 0);
      chk("E pop_1", int'(pop_1), 0);
      push0(8'h81);
      push0(8'h82);
      step();
      reset = 1'b1;
      clear_logs();
      repeat (8) step();
      if (pop_cls.size() > 0) chk("E first class", pop_cls[0], 0);
      else chk("E any pop", pop_cls.size(), 1);
      repeat (10) step();

      // Random traffic, backpressure and occasional resets.
      clear_logs();
      repeat (3000) begin
         step();
         if ($urandom_range(0, 2) != 0 && q0.size() < 12) push0(8'($urandom));
         if ($urandom_range(0, 2) == 0 && q1.size() < 12) push1(8'($urandom));
         dest_almost_full = ($urandom_range(0, 4) == 0);
         reset = ($urandom_range(0, 199) != 0);
         if (pop_cls.size() > 1000) clear_logs();
      end
      dest_almost_full = 1'b0;
      reset = 1'b1;
      repeat (60) step();
      chk("R drained q0", q0.size(), 0);
      chk("R drained q1", q1.size(), 0);

`ifdef VC_ARB_STATS_EN
      begin
         int pushed = 0;
         int guard = 0;
         do_reset();
         while ((pushed < 70000 || q0.size() > 0) && guard < 80000) begin
            step();
            if (q0.size() < 4 && pushed < 70000) begin
               push0(8'(pushed));
               pushed++;
            end
            if (pop_cls.size() > 1000) clear_logs();
            guard++;
         end
         repeat (6) step();
         chk("S cnt0 saturated", int'(cnt0), 16'hFFFF);
         chk("S cnt1 zero", int'(cnt1), 0);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
